tl45_muldiv: RTL and testbench
==============================

# tl45_muldiv

Parametrised iterative multiply/divide execute unit for the TL45 pipeline, sitting beside the single-cycle ALU in the execute stage. It replaces the fixed wait-counter multiply with a true one-bit-per-cycle shift-add multiplier and restoring divider. It adds high-word multiply, signed/unsigned divide and remainder, and defined divide-by-zero and overflow results. It uses the same stall/flush/operand-forward protocol as the rest of the pipeline.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 4, even).
- REGW, 4: destination register index width.
- i_clk  in  1  pipeline clock, all state updates on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_pipe_stall  in  1  downstream stall: hold output registers and final commit.
- i_pipe_flush  in  1  flush: abort any operation and clear outputs.
- o_pipe_stall  out  1  stall request to the previous stage (includes i_pipe_stall).
- i_valid  in  1  operation presented. Held stable by the previous stage while o_pipe_stall is high.
- i_op  in  3  operation code:
  - 0 MUL (low word)
  - 1 MULH (signed×signed, high word)
  - 2 MULHU (unsigned, high word)
  - 3 DIV
  - 4 DIVU
  - 5 REM
  - 6 REMU
  - 7 reserved, treated as no-op.
- i_dr  in  REGW  destination register; 0 means no writeback.
- i_a, i_b  in  WIDTH  operands (dividend/divisor for divide operations).
- o_of_reg  out  REGW  forward register index, combinational.
- o_of_val  out  WIDTH  forward value, combinational.
- o_valid  out  1  registered result valid.
- o_dr  out  REGW  registered destination.
- o_value  out  WIDTH  registered result.

## Operation
- States: IDLE, CALC.
- **IDLE**
  - If i_valid, i_op≠7 and no flush: latch operand magnitudes (absolute value for signed ops), result-sign flags, op and dr. Go to CALC with cnt=WIDTH-1.
  - i_op=7 with i_valid: o_valid=0, o_dr=0 next cycle; no stall.
- **CALC**, one iteration per cycle:
  - Multiply: if multiplier LSB is set, add multiplicand into the 2·WIDTH accumulator's upper half; then shift right.
  - Divide: shift the remainder:quotient pair left by one; subtract the divisor if it is ≤ the remainder, setting the quotient LSB.
  - cnt decrements each cycle.
- **Final iteration** (CALC, cnt=0):
  - Compute the fix-up result combinationally:
    - Negate for signed ops when the result-sign flag is set.
    - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
    - Select the low word (MUL) or high word (MULH/MULHU).
  - If i_pipe_stall is high, stay at cnt=0 and hold all state.
  - Otherwise load o_value, o_dr, o_valid=1 and go to IDLE.
- **Special cases**, detected at accept and forced at the final iteration:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = i_a.
  - Signed overflow (a = 1<<(WIDTH-1), b = all ones): DIV = a; REM = 0.
- **Outputs with no commit**: in any cycle without a commit, o_valid=0, o_dr=0, o_value=0 on the next edge, unless i_pipe_stall is high, in which case the output registers hold.
- **o_pipe_stall** = i_pipe_stall | (i_valid & i_op≠7 & !(state==CALC & cnt==0)).
- **Forwarding**:
  - o_of_reg/o_of_val = i_dr and the final result during CALC with cnt=0.
  - 0/0 otherwise, including while busy.
- **Flush**: has priority over stall and commit. State goes to IDLE; cnt, o_valid, o_dr and o_value are cleared on the same edge.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, o_valid=0, o_dr=0, o_value=0. Outputs are valid immediately on assertion. Reset mid-CALC aborts the operation with no result.
- Accept edge ends cycle T. CALC occupies cycles T+1..T+WIDTH. o_valid=1 in cycle T+WIDTH+1.
- Latency is WIDTH+1 cycles for every op, including special cases.
- o_pipe_stall is high in cycles T..T+WIDTH-1 and low in T+WIDTH, so the previous stage advances on that edge.
- Back-to-back ops: the next op is accepted in cycle T+WIDTH+1 (IDLE). o_valid is then 0 from T+WIDTH+2 until the next commit.
- Downstream stall during the final cycle extends CALC by one cycle per stalled cycle. Results are unchanged.
- Flush in the accept cycle means the op is not accepted.

## Test plan
- MUL, WIDTH=32, a=7, b=6, dr=3 → o_valid=1, o_dr=3, o_value=42 exactly 33 cycles after accept; o_pipe_stall low in the 33rd cycle only.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MUL 0x80000000×2 → 0.
- DIV a=-7, b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Edge cases during a DIV:
  - i_pipe_flush at cycle T+10 → IDLE next cycle; no o_valid; next op accepted with full latency.
  - i_reset_n low mid-CALC → all outputs 0 asynchronously.
- i_pipe_stall high for 3 cycles during the final CALC cycle → commit delayed by 3 cycles; o_of_reg held at dr throughout; value correct.

Source files
------------

// File: rtl/tl45_muldiv_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit: operand
// handshake, stall/flush controls, operand forwarding and registered result.
interface tl45_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
);
    logic             i_pipe_stall;
    logic             i_pipe_flush;
    logic             o_pipe_stall;
    logic             i_valid;
    logic [2:0]       i_op;
    logic [REGW-1:0]  i_dr;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [REGW-1:0]  o_of_reg;
    logic [WIDTH-1:0] o_of_val;
    logic             o_valid;
    logic [REGW-1:0]  o_dr;
    logic [WIDTH-1:0] o_value;

    // The execute stage side that feeds operands and consumes results.
    modport master (
        output i_pipe_stall, i_pipe_flush, i_valid, i_op, i_dr, i_a, i_b,
        input  o_pipe_stall, o_of_reg, o_of_val, o_valid, o_dr, o_value
    );

    // The multiply/divide unit itself.
    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_valid, i_op, i_dr, i_a, i_b,
        output o_pipe_stall, o_of_reg, o_of_val, o_valid, o_dr, o_value
    );
endinterface

// File: rtl/tl45_muldiv.sv
// TL45 iterative multiply/divide unit: one-bit-per-cycle shift-add multiplier
// and restoring divider sharing a single 2*WIDTH accumulator. Signed ops work
// on magnitudes and apply the result sign in a final combinational fix-up.
module tl45_muldiv #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
) (
    input logic           i_clk,
    input logic           i_reset_n,
    tl45_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_REMU  = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [REGW-1:0]    dr_q;
    logic               neg_q;
    logic               dzero_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;

    logic               accept;
    logic               final_cycle;
    logic               signed_in;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic               dzero_in;
    logic               ovf_in;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   result;

    assign accept      = (state == S_IDLE) && bus.i_valid && (bus.i_op != OP_NOP);
    assign final_cycle = (state == S_CALC) && (cnt == '0);

    // Operand preparation at accept: magnitudes, result sign and special cases.
    always_comb begin
        signed_in = (bus.i_op == OP_MULH) || (bus.i_op == OP_DIV) || (bus.i_op == OP_REM);
        sign_a    = signed_in & bus.i_a[WIDTH-1];
        sign_b    = signed_in & bus.i_b[WIDTH-1];
        a_mag     = sign_a ? (~bus.i_a + 1'b1) : bus.i_a;
        b_mag     = sign_b ? (~bus.i_b + 1'b1) : bus.i_b;
        case (bus.i_op)
            OP_MULH, OP_DIV: neg_in = sign_a ^ sign_b;
            OP_REM:          neg_in = sign_a;
            default:         neg_in = 1'b0;
        endcase
        dzero_in = (bus.i_op >= OP_DIV) && (bus.i_op <= OP_REMU) && (bus.i_b == '0);
        ovf_in   = ((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
                   (bus.i_a == MIN_NEG) && (bus.i_b == '1);
    end

    // One multiply or divide step on the shared accumulator.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
        if (op_q <= OP_MULHU) begin
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, opnd_q}) begin
            acc_next = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and word selection, built from the last step so the result is ready in the final cycle.
    always_comb begin
        prod_s = neg_q ? (~acc_next + 1'b1) : acc_next;
        quo_s  = neg_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
        rem_s  = neg_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:            result = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   result = dzero_q ? '1 : (ovf_q ? a_raw_q : quo_s);
            OP_REM, OP_REMU:   result = dzero_q ? a_raw_q : (ovf_q ? '0 : rem_s);
            default:           result = '0;
        endcase
    end

    // Hold the previous stage until the final cycle; forward only the finished result.
    assign bus.o_pipe_stall = bus.i_pipe_stall | (bus.i_valid & (bus.i_op != OP_NOP) & ~final_cycle);
    assign bus.o_of_reg     = final_cycle ? dr_q : '0;
    assign bus.o_of_val     = final_cycle ? result : '0;

    // Sequencer: accept, iterate WIDTH times, and wait out a downstream stall on the last step.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_MUL;
            dr_q    <= '0;
            neg_q   <= 1'b0;
            dzero_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_raw_q <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
        end else if (bus.i_pipe_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state   <= S_CALC;
            cnt     <= CW'(WIDTH-1);
            op_q    <= bus.i_op;
            dr_q    <= bus.i_dr;
            neg_q   <= neg_in;
            dzero_q <= dzero_in;
            ovf_q   <= ovf_in;
            a_raw_q <= bus.i_a;
            opnd_q  <= b_mag;
            acc_q   <= {{WIDTH{1'b0}}, a_mag};
        end else if (state == S_CALC) begin
            if (cnt != '0) begin
                acc_q <= acc_next;
                cnt   <= cnt - 1'b1;
            end else if (!bus.i_pipe_stall) begin
                acc_q <= acc_next;
                state <= S_IDLE;
            end
        end
    end

    // Result registers: load on commit, hold under stall, otherwise clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_valid <= 1'b0;
            bus.o_dr    <= '0;
            bus.o_value <= '0;
        end else if (bus.i_pipe_flush) begin
            bus.o_valid <= 1'b0;
            bus.o_dr    <= '0;
            bus.o_value <= '0;
        end else if (final_cycle && !bus.i_pipe_stall) begin
            bus.o_valid <= 1'b1;
            bus.o_dr    <= dr_q;
            bus.o_value <= result;
        end else if (!bus.i_pipe_stall) begin
            bus.o_valid <= 1'b0;
            bus.o_dr    <= '0;
            bus.o_value <= '0;
        end
    end
endmodule

// File: tb/tb_tl45_muldiv.sv
// Self-checking bench for tl45_muldiv: directed vectors, stall/flush/reset
// scenarios and back-to-back random ops against an arithmetic reference model.
module tb_tl45_muldiv;
    localparam int WIDTH = 32;
    localparam int REGW  = 4;

    logic i_clk;
    logic i_reset_n;
    int   errors;
    int   checks;

    tl45_muldiv_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

    tl45_muldiv #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    // Free-running pipeline clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference results from plain 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: begin p = sa * sb; p = p >> 32; end
            3'd2: begin p = ua * ub; p = p >> 32; end
            3'd3: begin
                if (b == 0) p = 64'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
                else p = sa / sb;
            end
            3'd4: p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            3'd5: begin
                if (b == 0) p = {32'd0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
                else p = sa % sb;
            end
            3'd6: p = (b == 0) ? {32'd0, a} : ua % ub;
            default: p = '0;
        endcase
        return p[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextCycle;
        @(posedge i_clk);
        #1;
    endtask

    // Present one op in the current cycle and follow it to its commit, optionally
    // holding the final cycle with a downstream stall. Returns in the commit cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] dr, input int stall_n);
        logic [31:0] exp;
        int          bad;
        exp = refModel(op, a, b);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_dr    = dr;
        #1;
        bad = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.o_pipe_stall !== 1'b1) bad++;
            if (bus.o_of_reg !== '0 || bus.o_of_val !== '0) bad++;
            if (k > 0 && (bus.o_valid !== 1'b0 || bus.o_dr !== '0 || bus.o_value !== '0)) bad++;
            nextCycle();
        end
        checkOutput("busy_profile", 64'(bad), 64'd0);
        for (int s = 0; s <= stall_n; s++) begin
            bus.i_pipe_stall = (s < stall_n);
            #1;
            checkOutput("final_stall", {63'd0, bus.o_pipe_stall}, {63'd0, bus.i_pipe_stall});
            checkOutput("fwd_reg", 64'(bus.o_of_reg), 64'(dr));
            checkOutput("fwd_val", 64'(bus.o_of_val), 64'(exp));
            checkOutput("no_early_valid", {63'd0, bus.o_valid}, 64'd0);
            nextCycle();
        end
        bus.i_pipe_stall = 1'b0;
        bus.i_valid      = 1'b0;
        checkOutput("commit_valid", {63'd0, bus.o_valid}, 64'd1);
        checkOutput("commit_dr", 64'(bus.o_dr), 64'(dr));
        checkOutput("commit_value", 64'(bus.o_value), 64'(exp));
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp1;
        int          bad;
        errors           = 0;
        checks           = 0;
        i_reset_n        = 1'b0;
        bus.i_pipe_stall = 1'b0;
        bus.i_pipe_flush = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_op         = 3'd0;
        bus.i_dr         = '0;
        bus.i_a          = '0;
        bus.i_b          = '0;
        #2;
        checkOutput("reset_valid", {63'd0, bus.o_valid}, 64'd0);
        checkOutput("reset_dr", 64'(bus.o_dr), 64'd0);
        checkOutput("reset_value", 64'(bus.o_value), 64'd0);
        checkOutput("reset_fwd", 64'(bus.o_of_reg), 64'd0);
        nextCycle();
        nextCycle();
        i_reset_n = 1'b1;
        nextCycle();

        applyStimulus(3'd0, 32'd7, 32'd6, 4'd3, 0);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 0);
        applyStimulus(3'd0, 32'h8000_0000, 32'd2, 4'd4, 0);
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 4'd5, 0);
        applyStimulus(3'd5, 32'hFFFF_FFF9, 32'd2, 4'd6, 0);
        applyStimulus(3'd4, 32'd100, 32'd7, 4'd7, 0);
        applyStimulus(3'd6, 32'd100, 32'd7, 4'd8, 0);
        applyStimulus(3'd4, 32'd5, 32'd0, 4'd9, 0);
        applyStimulus(3'd6, 32'd5, 32'd0, 4'd10, 0);
        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 0);
        applyStimulus(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd13, 0);

        // Reserved op: no stall, and clears the previous result.
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd7;
        bus.i_dr    = 4'd5;
        #1;
        checkOutput("nop_stall", {63'd0, bus.o_pipe_stall}, 64'd0);
        nextCycle();
        bus.i_valid = 1'b0;
        checkOutput("nop_valid", {63'd0, bus.o_valid}, 64'd0);
        checkOutput("nop_dr", 64'(bus.o_dr), 64'd0);

        // Downstream stall for three cycles on the final step.
        applyStimulus(3'd3, 32'd1000, 32'hFFFF_FFFD, 4'd14, 3);

        // Flush mid-divide aborts it entirely.
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd3;
        bus.i_a     = 32'd12345;
        bus.i_b     = 32'd17;
        bus.i_dr    = 4'd6;
        for (int k = 0; k < 10; k++) nextCycle();
        bus.i_pipe_flush = 1'b1;
        bus.i_valid      = 1'b0;
        nextCycle();
        bus.i_pipe_flush = 1'b0;
        bad = 0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            if (bus.o_valid !== 1'b0 || bus.o_of_reg !== '0 || bus.o_pipe_stall !== 1'b0) bad++;
            nextCycle();
        end
        checkOutput("flush_abort", 64'(bad), 64'd0);
        applyStimulus(3'd4, 32'd12345, 32'd17, 4'd6, 0);

        // Flush in the accept cycle beats both acceptance and a stall hold.
        bus.i_valid      = 1'b1;
        bus.i_op         = 3'd0;
        bus.i_a          = 32'd3;
        bus.i_b          = 32'd3;
        bus.i_pipe_flush = 1'b1;
        bus.i_pipe_stall = 1'b1;
        nextCycle();
        bus.i_valid      = 1'b0;
        bus.i_pipe_flush = 1'b0;
        bus.i_pipe_stall = 1'b0;
        checkOutput("flush_clears_held", {63'd0, bus.o_valid}, 64'd0);
        bad = 0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            if (bus.o_valid !== 1'b0 || bus.o_of_reg !== '0) bad++;
            nextCycle();
        end
        checkOutput("flush_no_accept", 64'(bad), 64'd0);

        // Outputs hold under stall, then asynchronous reset mid-divide clears everything.
        exp1 = refModel(3'd0, 32'd9, 32'd9);
        applyStimulus(3'd0, 32'd9, 32'd9, 4'd15, 0);
        bus.i_valid      = 1'b1;
        bus.i_op         = 3'd3;
        bus.i_a          = 32'd77;
        bus.i_b          = 32'd5;
        bus.i_dr         = 4'd2;
        bus.i_pipe_stall = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("stall_hold_valid", {63'd0, bus.o_valid}, 64'd1);
        checkOutput("stall_hold_value", 64'(bus.o_value), 64'(exp1));
        bus.i_valid      = 1'b0;
        bus.i_pipe_stall = 1'b0;
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {63'd0, bus.o_valid}, 64'd0);
        checkOutput("async_rst_value", 64'(bus.o_value), 64'd0);
        checkOutput("async_rst_dr", 64'(bus.o_dr), 64'd0);
        nextCycle();
        i_reset_n = 1'b1;
        nextCycle();
        applyStimulus(3'd5, 32'd77, 32'd5, 4'd2, 0);

        // Back-to-back random ops with occasional final-cycle stalls.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 6));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
